// File: rtl/turn_sequencer.sv
// Turn sequencer: accepts one turn command, inserts H-bridge dead time,
// drives the left/right code for a fixed cycle count, then pulses done.
module turn_sequencer #(
  parameter int         CNT_W       = 28,
  parameter int         SHORT_TICKS = 10000000,
  parameter int         LONG_TICKS  = 20000000,
  parameter int         GAP_TICKS   = 50000,
  parameter logic [3:0] CODE_LEFT   = 4'b1010,
  parameter logic [3:0] CODE_RIGHT  = 4'b0101
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       turn_req,
  input  logic       turn_dir,
  input  logic       turn_long,
  input  logic       abort,
  output logic [3:0] h_bridge_out,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       long_active
);

  localparam longint LIM = longint'(1) << CNT_W;

  if (SHORT_TICKS < 1 || longint'(SHORT_TICKS) >= LIM) begin : g_bad_short
    $error("turn_sequencer: SHORT_TICKS out of range");
  end
  if (LONG_TICKS < 1 || longint'(LONG_TICKS) >= LIM) begin : g_bad_long
    $error("turn_sequencer: LONG_TICKS out of range");
  end
  if (GAP_TICKS < 0 || longint'(GAP_TICKS) >= LIM) begin : g_bad_gap
    $error("turn_sequencer: GAP_TICKS out of range");
  end

  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_TICKS - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   =
    CNT_W'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_DRIVE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_long;
  logic [3:0]       r_out;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic             r_long_act;

  logic             w_accept;
  logic             w_drive_last;
  logic [3:0]       w_code_in;
  logic [3:0]       w_code_lat;

  assign w_accept     = (r_state == S_IDLE) && turn_req && !abort;
  assign w_drive_last = (r_cnt == (r_long ? LONG_LAST : SHORT_LAST));
  assign w_code_in    = turn_dir ? CODE_RIGHT : CODE_LEFT;
  assign w_code_lat   = r_dir ? CODE_RIGHT : CODE_LEFT;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dir      <= 1'b0;
      r_long     <= 1'b0;
      r_out      <= 4'b0000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_long_act <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dir     <= turn_dir;
            r_long    <= turn_long;
            r_aborted <= 1'b0;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            if (GAP_TICKS == 0) begin
              r_state    <= S_DRIVE;
              r_out      <= w_code_in;
              r_long_act <= turn_long;
            end else begin
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else if (r_cnt == GAP_LAST) begin
            r_state    <= S_DRIVE;
            r_cnt      <= '0;
            r_out      <= w_code_lat;
            r_long_act <= r_long;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DRIVE: begin
          // completion outranks a coincident abort
          if (w_drive_last || abort) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_out      <= 4'b0000;
            r_busy     <= 1'b0;
            r_long_act <= 1'b0;
            r_done     <= 1'b1;
            r_aborted  <= !w_drive_last;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_out   <= 4'b0000;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign h_bridge_out = r_out;
  assign busy         = r_busy;
  assign done         = r_done;
  assign aborted      = r_aborted;
  assign long_active  = r_long_act;

endmodule
